if_fetch: RTL and testbench

Instruction-fetch front end producing the `if_pc` / `if_inst` pair consumed by the IF/ID pipeline register. It generates sequential PCs, issues requests to instruction memory over a request/grant/response handshake, and buffers returned words in a 2-entry queue. It honours pipeline stalls and discards in-flight fetches on a branch redirect, so the IF/ID register sees only correct-path instructions.

---
 rtl/if_fetch_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 73 +++++++
 rtl/if_fetch.sv | 116 +++++++++++
 tb/tb_if_fetch.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// Shared types for the instruction-fetch front end: FSM encoding and the
// {pc, inst} entry held in the response buffer.
package if_fetch_pkg;

    localparam int          INST_ADDR_W = 32;
    localparam int          INST_W      = 32;
    localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;

    typedef enum logic [1:0] {
        FetchIdle  = 2'd0,
        FetchRun   = 2'd1,
        FetchFlush = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [INST_ADDR_W-1:0] pc;
        logic [INST_W-1:0]      inst;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Small DEPTH-entry FIFO with synchronous clear; used both for the response
// buffer and for the PC tags of outstanding requests.
module fetch_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 64,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CW-1:0]    count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop_i && !clear_i && (count_q != '0);
        do_push  = push_i && !clear_i && ((count_q != CW'(DEPTH)) || do_pop);
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; count_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch front end: sequential PC generation, req/gnt/rvalid memory
// handshake, 2-entry response buffer and branch-redirect flushing.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        if_valid_o
);

    localparam int          CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    fetch_state_e     state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]    kill_cnt_q, kill_cnt_d;
    logic [CW-1:0]    tag_cnt, buf_cnt, out_d;
    logic [CW:0]      in_use;
    logic [31:0]      tag_head;
    fetch_entry_t     buf_entry, buf_head;
    logic             grant, rsp_ok;
    logic             buf_push, buf_pop, buf_clear;

    // Tag queue occupancy doubles as the outstanding-request count.
    fetch_fifo #(.DEPTH(DEPTH), .WIDTH(INST_ADDR_W)) u_tag_fifo (
        .clk         (clk),
        .rst_n       (rst),
        .clear_i     (1'b0),
        .push_i      (grant),
        .push_data_i (fetch_pc_q),
        .pop_i       (rsp_ok),
        .head_o      (tag_head),
        .count_o     (tag_cnt)
    );

    fetch_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_buf_fifo (
        .clk         (clk),
        .rst_n       (rst),
        .clear_i     (buf_clear),
        .push_i      (buf_push),
        .push_data_i (buf_entry),
        .pop_i       (buf_pop),
        .head_o      (buf_head),
        .count_o     (buf_cnt)
    );

    assign if_valid_o  = (buf_cnt != '0);
    assign if_pc_o     = if_valid_o ? buf_head.pc   : ZERO_WORD;
    assign if_inst_o   = if_valid_o ? buf_head.inst : ZERO_WORD;
    assign imem_addr_o = fetch_pc_q;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        kill_cnt_d = kill_cnt_q;
        buf_clear  = 1'b0;
        buf_push   = 1'b0;
        buf_entry  = '{pc: tag_head, inst: imem_rdata_i};
        buf_pop    = if_valid_o && !stall_i && !branch_flag_i;
        in_use     = {1'b0, tag_cnt} + {1'b0, buf_cnt};

        // A head leaving this cycle frees its slot, so zero-wait memory streams one word per cycle.
        imem_req_o = (state_q == FetchRun) && !branch_flag_i &&
                     (in_use < DEPTH_W + {{CW{1'b0}}, buf_pop});
        grant      = imem_req_o && imem_gnt_i;
        rsp_ok     = imem_rvalid_i && (tag_cnt != '0);
        out_d      = tag_cnt + CW'(grant) - CW'(rsp_ok);

        if (rsp_ok) begin
            if (kill_cnt_q != '0) kill_cnt_d = kill_cnt_q - CW'(1);
            else                  buf_push   = !branch_flag_i;
        end
        if (grant) fetch_pc_d = fetch_pc_q + 32'd4;

        case (state_q)
            FetchIdle:  state_d = FetchRun;
            FetchRun:   state_d = FetchRun;
            FetchFlush: if (kill_cnt_d == '0) state_d = FetchRun;
            default:    state_d = FetchIdle;
        endcase

        // Everything in flight now belongs to the wrong path.
        if (branch_flag_i) begin
            buf_clear  = 1'b1;
            fetch_pc_d = branch_target_i;
            kill_cnt_d = out_d;
            state_d    = (out_d != '0) ? FetchFlush : FetchRun;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= FetchIdle;
            fetch_pc_q <= RESET_PC;
            kill_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            kill_cnt_q <= kill_cnt_d;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: behavioural instruction memory plus a scoreboard
// of {pc, inst} pairs pushed at grant and popped when IF/ID consumes an entry.
module tb_if_fetch;
    import if_fetch_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i, branch_flag_i;
    logic [31:0] branch_target_i;
    logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
    logic [31:0] imem_addr_o, imem_rdata_i;
    logic [31:0] if_pc_o, if_inst_o;
    logic        if_valid_o;

    always #5 clk = ~clk;

    if_fetch #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_gnt_i      (imem_gnt_i),
        .imem_rvalid_i   (imem_rvalid_i),
        .imem_rdata_i    (imem_rdata_i),
        .if_pc_o         (if_pc_o),
        .if_inst_o       (if_inst_o),
        .if_valid_o      (if_valid_o)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] pend_q[$];
    logic [31:0] exp_addr, wait_addr, last_pc, prev_pc;
    int          checks = 0, errors = 0;
    int          gnt_wait, wait_cnt, consumed;
    bit          hold_rsp, force_gnt, seen_wrap, found;
    int          n0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_req"},   32'(imem_req_o), 32'd0);
        check({pfx, "_addr"},  imem_addr_o,     RESET_PC);
        check({pfx, "_pc"},    if_pc_o,         32'd0);
        check({pfx, "_inst"},  if_inst_o,       32'd0);
        check({pfx, "_valid"}, 32'(if_valid_o), 32'd0);
    endtask

    task automatic model_clear();
        pend_q.delete();
        exp_q.delete();
        exp_addr = RESET_PC;
        wait_cnt = 0;
    endtask

    // One clock cycle: memory drives at the falling edge, state advances at the rising edge.
    task automatic tick();
        logic        granted, rsp;
        logic [31:0] gaddr;
        exp_t        e;
        @(negedge clk);
        if (!hold_rsp && pend_q.size() > 0) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(pend_q[0]);
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'h0;
        end
        imem_gnt_i = force_gnt || (imem_req_o && (wait_cnt >= gnt_wait));
        granted    = imem_req_o && imem_gnt_i;
        rsp        = imem_rvalid_i;
        gaddr      = imem_addr_o;
        if (imem_req_o && wait_cnt > 0) check("addr_stable", imem_addr_o, wait_addr);
        if (granted) check("req_addr", imem_addr_o, exp_addr);
        if (if_valid_o && !stall_i && !branch_flag_i) begin
            check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("if_pc", if_pc_o, e.pc);
                check("if_inst", if_inst_o, e.inst);
            end
            if (prev_pc == 32'hFFFF_FFFC && if_pc_o == 32'h0) seen_wrap = 1'b1;
            prev_pc = if_pc_o;
            last_pc = if_pc_o;
            consumed++;
        end
        if (granted || !imem_req_o) wait_cnt = 0;
        else begin
            if (wait_cnt == 0) wait_addr = imem_addr_o;
            wait_cnt++;
        end
        @(posedge clk);
        #1;
        if (rsp) void'(pend_q.pop_front());
        if (granted) begin
            pend_q.push_back(gaddr);
            exp_q.push_back('{pc: gaddr, inst: mem_word(gaddr)});
            exp_addr = exp_addr + 32'd4;
        end
        if (branch_flag_i) begin
            exp_q.delete();
            exp_addr = branch_target_i;
        end
    endtask

    // Called one time unit after a rising edge.
    task automatic release_reset();
        rst = 1'b1;
        #1;
        check("idle_no_req", 32'(imem_req_o), 32'd0);
        tick();
        check("first_req", 32'(imem_req_o), 32'd1);
        check("first_addr", imem_addr_o, RESET_PC);
    endtask

    task automatic wait_first(input logic [31:0] exp_pc, input string tag);
        int start;
        start   = consumed;
        last_pc = ~exp_pc;
        for (int i = 0; i < 20 && consumed == start; i++) tick();
        check(tag, last_pc, exp_pc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; stall_i = 1'b0; branch_flag_i = 1'b0; branch_target_i = 32'h0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
        hold_rsp = 1'b0; force_gnt = 1'b0; gnt_wait = 0; consumed = 0;
        last_pc = '1; prev_pc = '1; seen_wrap = 1'b0; found = 1'b0;
        model_clear();
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        release_reset();

        // Zero-wait stream until PC 0x8 sits at the head, then hold IF/ID for 3 cycles.
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            found = if_valid_o && (if_pc_o == 32'h8);
        end
        check("head_reaches_8", 32'(found), 32'd1);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", 32'(if_valid_o), 32'd1);
            check("stall_head_pc", if_pc_o, 32'h8);
            check("stall_no_req", 32'(imem_req_o), 32'd0);
        end
        check("stall_buf_full", 32'(dut.buf_cnt), 32'd2);
        stall_i = 1'b0;

        repeat (3) tick();
        n0 = consumed;
        repeat (8) tick();
        check("throughput", 32'(consumed - n0), 32'd8);

        // Branch with two requests outstanding.
        hold_rsp = 1'b1;
        repeat (3) tick();
        check("two_outstanding", 32'(dut.tag_cnt), 32'd2);
        branch_flag_i = 1'b1; branch_target_i = 32'h100;
        tick();
        branch_flag_i = 1'b0;
        check("flush_state", 32'(dut.state_q), 32'(FetchFlush));
        check("flush_kill_cnt", 32'(dut.kill_cnt_q), 32'd2);
        check("flush_buf_cleared", 32'(if_valid_o), 32'd0);
        tick();
        check("flush_no_req", 32'(imem_req_o), 32'd0);
        hold_rsp = 1'b0;
        repeat (2) tick();
        check("flush_drained_valid", 32'(if_valid_o), 32'd0);
        check("redirect_req", 32'(imem_req_o), 32'd1);
        check("redirect_addr", imem_addr_o, 32'h100);
        wait_first(32'h100, "first_after_branch");

        // Branch coinciding with a response and a memory grant.
        repeat (4) tick();
        hold_rsp = 1'b1;
        repeat (2) tick();
        check("two_outstanding_b", 32'(dut.tag_cnt), 32'd2);
        hold_rsp = 1'b0; force_gnt = 1'b1;
        branch_flag_i = 1'b1; branch_target_i = 32'h200;
        tick();
        branch_flag_i = 1'b0; force_gnt = 1'b0;
        check("same_cycle_kill_cnt", 32'(dut.kill_cnt_q), 32'd1);
        check("same_cycle_state", 32'(dut.state_q), 32'(FetchFlush));
        check("same_cycle_valid", 32'(if_valid_o), 32'd0);
        tick();
        check("same_cycle_redirect_addr", imem_addr_o, 32'h200);
        wait_first(32'h200, "first_after_same_cycle_branch");

        // Two-wait-cycle grants across the 32-bit PC wrap.
        repeat (3) tick();
        gnt_wait = 2;
        branch_flag_i = 1'b1; branch_target_i = 32'hFFFF_FFF8;
        tick();
        branch_flag_i = 1'b0;
        seen_wrap = 1'b0;
        n0 = consumed;
        repeat (40) tick();
        check("wrap_seen", 32'(seen_wrap), 32'd1);
        check("wait_progress", 32'(consumed - n0 >= 6), 32'd1);

        // Asynchronous reset in the middle of a full buffer.
        gnt_wait = 0;
        repeat (3) tick();
        stall_i = 1'b1;
        repeat (4) tick();
        check("pre_reset_full", 32'(dut.buf_cnt), 32'd2);
        check("pre_reset_valid", 32'(if_valid_o), 32'd1);
        #3;
        rst = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        model_clear();
        stall_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
        @(posedge clk);
        #1;
        check("held_reset_valid", 32'(if_valid_o), 32'd0);
        release_reset();
        wait_first(RESET_PC, "restart_first_pc");
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
